flag_reg_stack: RTL and testbench

- Parametrised successor to the CPU flag registers: NFLAGS-wide live flag register plus a DEPTH-entry save/restore stack for interrupt/call context.
- Adds per-bit masked updates, sticky (set-only) flag bits, explicit clear, and stack overflow/underflow detection.
- Sits between the ALU/control flag producers and the branch/interrupt logic; all outputs are registered.

---
 rtl/flag_reg_stack.sv | 188 ++++++++++++++++++
 tb/tb_flag_reg_stack.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_reg_stack.sv
// flag_reg_stack: live CPU flag register with a save/restore stack for interrupt and
// call context.
//
// The live register is NFLAGS wide. Each bit can be updated or cleared on its own.
// Bits selected by STICKY_MASK are set-only: an update can set them but never clear
// them. The stack holds DEPTH entries. A lone push saves the pre-update flags, and a
// lone pop restores the most recently saved entry. Overflow and underflow attempts
// are recorded in sticky error bits.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset, overrides every other input
//   upd_en    in   [NFLAGS] per-bit update enable
//   upd_val   in   [NFLAGS] per-bit new value
//   clr_mask  in   [NFLAGS] per-bit clear request
//   push      in   save the live flags to the stack
//   pop       in   restore the live flags from the stack
//   err_clr   in   clear ovf_err and unf_err
//   flags     out  [NFLAGS] live flag register
//   depth     out  [DW] number of occupied stack entries
//   full      out  depth == DEPTH
//   empty     out  depth == 0
//   ovf_err   out  sticky: push attempted while full
//   unf_err   out  sticky: pop attempted while empty
//
// Every output comes from a flop, so no input reaches an output in the same cycle.

module flag_reg_stack #(
    parameter int unsigned          NFLAGS      = 13,
    parameter int unsigned          DEPTH       = 4,
    parameter logic [NFLAGS-1:0]    STICKY_MASK = '0,
    parameter logic [NFLAGS-1:0]    RESET_VAL   = '0,
    localparam int unsigned         DW          = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NFLAGS-1:0] upd_en,
    input  logic [NFLAGS-1:0] upd_val,
    input  logic [NFLAGS-1:0] clr_mask,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    output logic [NFLAGS-1:0] flags,
    output logic [DW-1:0]     depth,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err
);

    // Stack index width. It is kept at least one bit wide so that DEPTH=1 still
    // elaborates.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DW-1:0] DepthMax = DW'(DEPTH);
    localparam logic [DW-1:0] DepthOne = DW'(1);

    if (DEPTH < 1) begin : g_depth_check
        $error("flag_reg_stack: DEPTH must be at least 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [NFLAGS-1:0] stack_q [DEPTH];
    logic [NFLAGS-1:0] stack_d [DEPTH];

    // ------------------------------------------------------------------
    // Per-bit update and clear
    // ------------------------------------------------------------------
    logic [NFLAGS-1:0] set_v;
    logic [NFLAGS-1:0] plain_n;
    logic [NFLAGS-1:0] sticky_n;
    logic [NFLAGS-1:0] upd_n;

    always_comb begin
        set_v    = upd_en & upd_val;
        // Non-sticky bits: the update selects the new value, then a clear always wins.
        plain_n  = (upd_en & upd_val) | (~upd_en & flags_q);
        plain_n  = plain_n & ~clr_mask;
        // Sticky bits: OR in the sets. A clear only takes effect when no set arrives
        // in the same cycle, so no event is lost.
        sticky_n = flags_q | set_v;
        sticky_n = sticky_n & ~(clr_mask & ~set_v);
        upd_n    = (STICKY_MASK & sticky_n) | (~STICKY_MASK & plain_n);
    end

    // ------------------------------------------------------------------
    // Stack control
    // ------------------------------------------------------------------
    // A push and a pop in the same cycle cancel each other. Neither touches the
    // stack, and neither flags an error.
    logic           lone_push;
    logic           lone_pop;
    logic           push_ok;
    logic           pop_ok;
    logic [AW-1:0]  push_idx;
    logic [AW-1:0]  pop_idx;
    logic [DW-1:0]  depth_m1;

    always_comb begin
        lone_push = push & ~pop;
        lone_pop  = pop & ~push;
        push_ok   = lone_push & ~full_q;
        pop_ok    = lone_pop & ~empty_q;
        depth_m1  = depth_q - DepthOne;
        push_idx  = AW'(depth_q);
        pop_idx   = AW'(depth_m1);
    end

    always_comb begin
        stack_d = stack_q;
        if (push_ok) begin
            stack_d[push_idx] = flags_q;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        flags_d = upd_n;
        depth_d = depth_q;

        if (push_ok) begin
            depth_d = depth_q + DepthOne;
        end else if (pop_ok) begin
            // The restore overrides any update or clear issued in the same cycle.
            flags_d = stack_q[pop_idx];
            depth_d = depth_m1;
        end

        full_d  = (depth_d == DepthMax);
        empty_d = (depth_d == '0);

        // A new error beats a same-cycle err_clr.
        ovf_d = ovf_q & ~err_clr;
        unf_d = unf_q & ~err_clr;
        if (lone_push && full_q) begin
            ovf_d = 1'b1;
        end
        if (lone_pop && empty_q) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= RESET_VAL;
            depth_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents are don't-care after reset, so the array has no reset. The
    // depth counter and the other state are cleared on reset, so no stale entry
    // can ever be read back.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign flags   = flags_q;
    assign depth   = depth_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

// File: tb/tb_flag_reg_stack.sv
module tb_flag_reg_stack;

    localparam int unsigned NF = 13;
    localparam int unsigned DP = 4;
    localparam logic [NF-1:0] SMASK = 13'h0004;

    logic          clk;
    logic          rst;
    logic [NF-1:0] upd_en;
    logic [NF-1:0] upd_val;
    logic [NF-1:0] clr_mask;
    logic          push;
    logic          pop;
    logic          err_clr;

    logic [NF-1:0] d_flags, s_flags;
    logic [2:0]    d_depth, s_depth;
    logic          d_full, s_full, d_empty, s_empty;
    logic          d_ovf, s_ovf, d_unf, s_unf;

    int checks = 0;
    int errors = 0;

    // Default instance: no sticky bits.
    flag_reg_stack #(
        .NFLAGS      (NF),
        .DEPTH       (DP),
        .STICKY_MASK (13'h0000),
        .RESET_VAL   (13'h0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .upd_en   (upd_en),
        .upd_val  (upd_val),
        .clr_mask (clr_mask),
        .push     (push),
        .pop      (pop),
        .err_clr  (err_clr),
        .flags    (d_flags),
        .depth    (d_depth),
        .full     (d_full),
        .empty    (d_empty),
        .ovf_err  (d_ovf),
        .unf_err  (d_unf)
    );

    // Sticky instance: bit 2 (of) is set-only.
    flag_reg_stack #(
        .NFLAGS      (NF),
        .DEPTH       (DP),
        .STICKY_MASK (SMASK),
        .RESET_VAL   (13'h0000)
    ) dut_s (
        .clk      (clk),
        .rst      (rst),
        .upd_en   (upd_en),
        .upd_val  (upd_val),
        .clr_mask (clr_mask),
        .push     (push),
        .pop      (pop),
        .err_clr  (err_clr),
        .flags    (s_flags),
        .depth    (s_depth),
        .full     (s_full),
        .empty    (s_empty),
        .ovf_err  (s_ovf),
        .unf_err  (s_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [NF-1:0] flags;
        logic [2:0]    depth;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          unf;
    } obs_t;

    typedef struct packed {
        obs_t d;
        obs_t s;
    } pair_t;

    pair_t sb_q[$];

    logic [NF-1:0] m_flags [2];
    logic [2:0]    m_depth [2];
    logic          m_ovf   [2];
    logic          m_unf   [2];
    logic [NF-1:0] m_stk   [2][DP];

    function automatic logic [NF-1:0] bit_next(input logic [NF-1:0] f, input logic [NF-1:0] en,
                                               input logic [NF-1:0] val, input logic [NF-1:0] clr,
                                               input logic [NF-1:0] sticky);
        logic [NF-1:0] n;
        for (int i = 0; i < NF; i++) begin
            if (sticky[i]) begin
                n[i] = f[i] | (en[i] & val[i]);
                if (clr[i] && !(en[i] && val[i])) n[i] = 1'b0;
            end else begin
                n[i] = en[i] ? val[i] : f[i];
                if (clr[i]) n[i] = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic model_step(input int k, input logic [NF-1:0] sticky);
        logic [NF-1:0] n;
        if (rst) begin
            m_flags[k] = 13'h0000;
            m_depth[k] = 3'd0;
            m_ovf[k]   = 1'b0;
            m_unf[k]   = 1'b0;
        end else begin
            n = bit_next(m_flags[k], upd_en, upd_val, clr_mask, sticky);
            if (err_clr) begin
                m_ovf[k] = 1'b0;
                m_unf[k] = 1'b0;
            end
            if (push && !pop) begin
                if (m_depth[k] == 3'(DP)) m_ovf[k] = 1'b1;
                else begin
                    m_stk[k][m_depth[k][1:0]] = m_flags[k];
                    m_depth[k] = m_depth[k] + 3'd1;
                end
            end
            if (pop && !push) begin
                if (m_depth[k] == 3'd0) m_unf[k] = 1'b1;
                else begin
                    m_depth[k] = m_depth[k] - 3'd1;
                    n = m_stk[k][m_depth[k][1:0]];
                end
            end
            m_flags[k] = n;
        end
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t o;
        o.flags = m_flags[k];
        o.depth = m_depth[k];
        o.full  = (m_depth[k] == 3'(DP));
        o.empty = (m_depth[k] == 3'd0);
        o.ovf   = m_ovf[k];
        o.unf   = m_unf[k];
        return o;
    endfunction

    // Drive one cycle: predict, push the expectation, and let the monitor compare.
    task automatic tick();
        pair_t p;
        model_step(0, 13'h0000);
        model_step(1, SMASK);
        p.d = model_obs(0);
        p.s = model_obs(1);
        sb_q.push_back(p);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; upd_en = '0; upd_val = '0; clr_mask = '0; push = 0; pop = 0; err_clr = 0;
    endtask

    // Monitor: pops each expectation on the falling edge that follows its rising edge.
    initial begin
        pair_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks += 12;
                if (d_flags !== e.d.flags) begin errors++; $display("FAIL sb_d_flags got %h exp %h", d_flags, e.d.flags); end
                if (d_depth !== e.d.depth) begin errors++; $display("FAIL sb_d_depth got %0d exp %0d", d_depth, e.d.depth); end
                if (d_full  !== e.d.full)  begin errors++; $display("FAIL sb_d_full got %b exp %b", d_full, e.d.full); end
                if (d_empty !== e.d.empty) begin errors++; $display("FAIL sb_d_empty got %b exp %b", d_empty, e.d.empty); end
                if (d_ovf   !== e.d.ovf)   begin errors++; $display("FAIL sb_d_ovf got %b exp %b", d_ovf, e.d.ovf); end
                if (d_unf   !== e.d.unf)   begin errors++; $display("FAIL sb_d_unf got %b exp %b", d_unf, e.d.unf); end
                if (s_flags !== e.s.flags) begin errors++; $display("FAIL sb_s_flags got %h exp %h", s_flags, e.s.flags); end
                if (s_depth !== e.s.depth) begin errors++; $display("FAIL sb_s_depth got %0d exp %0d", s_depth, e.s.depth); end
                if (s_full  !== e.s.full)  begin errors++; $display("FAIL sb_s_full got %b exp %b", s_full, e.s.full); end
                if (s_empty !== e.s.empty) begin errors++; $display("FAIL sb_s_empty got %b exp %b", s_empty, e.s.empty); end
                if (s_ovf   !== e.s.ovf)   begin errors++; $display("FAIL sb_s_ovf got %b exp %b", s_ovf, e.s.ovf); end
                if (s_unf   !== e.s.unf)   begin errors++; $display("FAIL sb_s_unf got %b exp %b", s_unf, e.s.unf); end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic do_reset();
        idle(); rst = 1; tick(); idle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (d_flags !== 13'h0000 || d_depth !== 3'd0 || d_empty !== 1'b1 || d_full !== 1'b0 ||
            d_ovf !== 1'b0 || d_unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got flags=%h depth=%0d e=%b f=%b o=%b u=%b exp 0000/0/1/0/0/0",
                     d_flags, d_depth, d_empty, d_full, d_ovf, d_unf);
        end
        upd_en = 13'h0003; upd_val = 13'h0001; tick(); idle();
        checks++;
        if (d_flags !== 13'h0001) begin errors++; $display("FAIL first_update got %h exp 0001", d_flags); end
    endtask

    task automatic test_masked_update();
        upd_en = 13'h1FFF; upd_val = 13'h1FFF; tick(); idle();
        upd_en = 13'h0010; upd_val = 13'h0000; clr_mask = 13'h0001; tick(); idle();
        checks++;
        if (d_flags !== 13'h1FEE) begin errors++; $display("FAIL masked_upd_clr got %h exp 1FEE", d_flags); end
        upd_en = 13'h0004; upd_val = 13'h0004; clr_mask = 13'h0004; tick(); idle();
        checks++;
        if (d_flags !== 13'h1FEA) begin errors++; $display("FAIL clear_wins got %h exp 1FEA", d_flags); end
    endtask

    task automatic test_sticky();
        do_reset();
        upd_en = 13'h0004; upd_val = 13'h0004; tick(); idle();
        checks++;
        if (s_flags[2] !== 1'b1) begin errors++; $display("FAIL sticky_set got %b exp 1", s_flags[2]); end
        upd_en = 13'h0004; upd_val = 13'h0000; tick(); idle();
        checks++;
        if (s_flags[2] !== 1'b1) begin errors++; $display("FAIL sticky_hold got %b exp 1", s_flags[2]); end
        clr_mask = 13'h0004; tick(); idle();
        checks++;
        if (s_flags[2] !== 1'b0) begin errors++; $display("FAIL sticky_clear got %b exp 0", s_flags[2]); end
        upd_en = 13'h0004; upd_val = 13'h0004; clr_mask = 13'h0004; tick(); idle();
        checks++;
        if (s_flags[2] !== 1'b1) begin errors++; $display("FAIL sticky_set_beats_clr got %b exp 1", s_flags[2]); end
    endtask

    task automatic load_and_push(input logic [NF-1:0] v);
        upd_en = 13'h1FFF; upd_val = v; tick(); idle();
        push = 1; tick(); idle();
    endtask

    task automatic test_fill_drain();
        logic [NF-1:0] vals [4];
        vals[0] = 13'h0011; vals[1] = 13'h0022; vals[2] = 13'h0044; vals[3] = 13'h0088;
        do_reset();
        for (int i = 0; i < 4; i++) load_and_push(vals[i]);
        checks++;
        if (d_depth !== 3'd4 || d_full !== 1'b1) begin
            errors++; $display("FAIL fill got depth=%0d full=%b exp 4/1", d_depth, d_full);
        end
        push = 1; tick(); idle();
        checks++;
        if (d_ovf !== 1'b1 || d_depth !== 3'd4) begin
            errors++; $display("FAIL overflow got ovf=%b depth=%0d exp 1/4", d_ovf, d_depth);
        end
        for (int i = 3; i >= 0; i--) begin
            pop = 1; tick(); idle();
            checks++;
            if (d_flags !== vals[i]) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, d_flags, vals[i]); end
        end
        checks++;
        if (d_empty !== 1'b1) begin errors++; $display("FAIL drained_empty got %b exp 1", d_empty); end
        pop = 1; tick(); idle();
        checks++;
        if (d_unf !== 1'b1 || d_flags !== 13'h0011) begin
            errors++; $display("FAIL underflow got unf=%b flags=%h exp 1/0011", d_unf, d_flags);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        upd_en = 13'h1FFF; upd_val = 13'h0011; tick(); idle();
        push = 1; upd_en = 13'h1FFF; upd_val = 13'h00FF; tick(); idle();
        checks++;
        if (d_flags !== 13'h00FF || d_depth !== 3'd1) begin
            errors++; $display("FAIL push_with_upd got flags=%h depth=%0d exp 00FF/1", d_flags, d_depth);
        end
        pop = 1; upd_en = 13'h1FFF; upd_val = 13'h0F0F; tick(); idle();
        checks++;
        if (d_flags !== 13'h0011) begin errors++; $display("FAIL pop_wins got %h exp 0011", d_flags); end
        push = 1; pop = 1; tick(); idle();
        checks++;
        if (d_depth !== 3'd0 || d_ovf !== 1'b0 || d_unf !== 1'b0) begin
            errors++; $display("FAIL push_pop_cancel got depth=%0d o=%b u=%b exp 0/0/0", d_depth, d_ovf, d_unf);
        end
        for (int i = 0; i < 4; i++) begin push = 1; tick(); idle(); end
        push = 1; err_clr = 1; tick(); idle();
        checks++;
        if (d_ovf !== 1'b1) begin errors++; $display("FAIL set_beats_errclr got %b exp 1", d_ovf); end
        err_clr = 1; tick(); idle();
        checks++;
        if (d_ovf !== 1'b0) begin errors++; $display("FAIL err_clr got %b exp 0", d_ovf); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        for (int i = 0; i < 3; i++) load_and_push(13'(i + 5));
        push = 1; rst = 1; upd_en = 13'h1FFF; upd_val = 13'h1234; tick(); idle();
        checks++;
        if (d_depth !== 3'd0 || d_flags !== 13'h0000 || d_ovf !== 1'b0 || d_unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op got depth=%0d flags=%h o=%b u=%b exp 0/0000/0/0",
                     d_depth, d_flags, d_ovf, d_unf);
        end
        pop = 1; tick(); idle();
        checks++;
        if (d_unf !== 1'b1) begin errors++; $display("FAIL pop_after_reset got %b exp 1", d_unf); end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_masked_update();
        test_sticky();
        test_fill_drain();
        test_simultaneous();
        test_reset_mid_op();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d exp 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

endmodule
